// File: rtl/operand_fetch_pkg.sv
// Shared types and helpers for the operand fetch issue stage.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int REG_ADDR_SIZE_DEF = 4;
  localparam int NUM_REGS          = 1 << REG_ADDR_SIZE_DEF;

  function automatic logic idx_is_zero(input logic [31:0] idx);
    return idx == 32'd0;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction, register-file, writeback and execute buses of the operand fetch stage.
interface operand_fetch_if #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_SIZE = 4,
  parameter int CTRL_W        = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [REG_ADDR_SIZE-1:0] in_rs1;
  logic [REG_ADDR_SIZE-1:0] in_rs2;
  logic [REG_ADDR_SIZE-1:0] in_rd;
  logic                     in_wen;
  logic [CTRL_W-1:0]        in_ctrl;

  logic                     rf_en;
  logic [REG_ADDR_SIZE-1:0] rf_r1;
  logic [REG_ADDR_SIZE-1:0] rf_r2;
  logic [REG_ADDR_SIZE-1:0] rf_write;
  logic [WORD_SIZE-1:0]     rf_data;
  logic [WORD_SIZE-1:0]     rf_out1;
  logic [WORD_SIZE-1:0]     rf_out2;

  logic                     wb_valid;
  logic [REG_ADDR_SIZE-1:0] wb_rd;
  logic [WORD_SIZE-1:0]     wb_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_SIZE-1:0]     out_a;
  logic [WORD_SIZE-1:0]     out_b;
  logic [REG_ADDR_SIZE-1:0] out_rd;
  logic                     out_wen;
  logic [CTRL_W-1:0]        out_ctrl;

  // Environment side: decoder, register file, writeback source and execute.
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen, in_ctrl,
    input  in_ready,
    input  rf_en, rf_r1, rf_r2, rf_write, rf_data,
    output rf_out1, rf_out2,
    output wb_valid, wb_rd, wb_data,
    input  out_valid, out_a, out_b, out_rd, out_wen, out_ctrl,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen, in_ctrl,
    output in_ready,
    output rf_en, rf_r1, rf_r2, rf_write, rf_data,
    input  rf_out1, rf_out2,
    input  wb_valid, wb_rd, wb_data,
    output out_valid, out_a, out_b, out_rd, out_wen, out_ctrl,
    input  out_ready
  );
endinterface

// File: rtl/opfetch_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set on issue, cleared on writeback.
module opfetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int REG_ADDR_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [REG_ADDR_SIZE-1:0] set_idx,
  input  logic                     clr_en,
  input  logic [REG_ADDR_SIZE-1:0] clr_idx,
  input  logic [REG_ADDR_SIZE-1:0] q_rs1,
  input  logic [REG_ADDR_SIZE-1:0] q_rs2,
  input  logic [REG_ADDR_SIZE-1:0] q_rd,
  output logic                     pend_rs1,
  output logic                     pend_rs2,
  output logic                     pend_rd
);

  localparam int NR = 1 << REG_ADDR_SIZE;

  logic [NR-1:0] pend;
  logic [NR-1:0] set_vec;
  logic [NR-1:0] clr_vec;
  logic [NR-1:0] pend_nxt;

  // A same-cycle set overrides the clear; register 0 can never be pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    pend_nxt    = (pend & ~clr_vec) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign pend_rs1 = pend[q_rs1];
  assign pend_rs2 = pend[q_rs2];
  assign pend_rd  = pend[q_rd];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: hazard-checked accept, register-file read with writeback forwarding, operand hold.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_SIZE = 4,
  parameter int CTRL_W        = 8
) (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0] state;

  logic                     pend_rs1, pend_rs2, pend_rd;
  logic                     wb_hit1, wb_hit2;
  logic                     hazard, is_idle, accept, sb_set;

  logic [REG_ADDR_SIZE-1:0] rs1_p0, rs2_p0, rd_p0;
  logic                     wen_p0;
  logic [CTRL_W-1:0]        ctrl_p0;
  logic                     fwd1_p0, fwd2_p0;
  logic [WORD_SIZE-1:0]     fwd_data_p0;

  logic                     vld_p1;
  logic [WORD_SIZE-1:0]     a_p1, b_p1;
  logic [REG_ADDR_SIZE-1:0] rd_p1;
  logic                     wen_p1;
  logic [CTRL_W-1:0]        ctrl_p1;

  opfetch_scoreboard #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_idx  (bus.in_rd),
    .clr_en   (bus.wb_valid),
    .clr_idx  (bus.wb_rd),
    .q_rs1    (bus.in_rs1),
    .q_rs2    (bus.in_rs2),
    .q_rd     (bus.in_rd),
    .pend_rs1 (pend_rs1),
    .pend_rs2 (pend_rs2),
    .pend_rd  (pend_rd)
  );

  // A source whose writeback lands this cycle is not a hazard; it is forwarded instead.
  assign wb_hit1 = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
  assign wb_hit2 = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
  assign hazard  = (pend_rs1 && !wb_hit1) || (pend_rs2 && !wb_hit2) ||
                   (bus.in_wen && !idx_is_zero(32'(bus.in_rd)) && pend_rd);
  assign is_idle = (state == ST_IDLE);
  assign accept  = bus.in_valid && bus.in_ready;
  assign sb_set  = accept && bus.in_wen && !idx_is_zero(32'(bus.in_rd));

  assign bus.in_ready = is_idle && !hazard;
  assign bus.rf_en    = rst_n;
  assign bus.rf_write = (bus.wb_valid && rst_n) ? bus.wb_rd : '0;
  assign bus.rf_data  = bus.wb_data;
  assign bus.rf_r1    = is_idle ? bus.in_rs1 : rs1_p0;
  assign bus.rf_r2    = is_idle ? bus.in_rs2 : rs2_p0;

  // Stage p0: capture the accepted instruction and any same-edge writeback value
  always_ff @(posedge clk) begin
    if (accept) begin
      rs1_p0      <= bus.in_rs1;
      rs2_p0      <= bus.in_rs2;
      rd_p0       <= bus.in_rd;
      wen_p0      <= bus.in_wen;
      ctrl_p0     <= bus.in_ctrl;
      fwd_data_p0 <= bus.wb_data;
    end
  end

  // Stage p1: select register-file or forwarded operands and hold them for execute
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fwd1_p0 <= 1'b0;
      fwd2_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      rd_p1   <= '0;
      wen_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_READ;
            fwd1_p0 <= wb_hit1 && !idx_is_zero(32'(bus.in_rs1));
            fwd2_p0 <= wb_hit2 && !idx_is_zero(32'(bus.in_rs2));
          end
        end
        ST_READ: begin
          state   <= ST_HOLD;
          vld_p1  <= 1'b1;
          a_p1    <= fwd1_p0 ? fwd_data_p0 : bus.rf_out1;
          b_p1    <= fwd2_p0 ? fwd_data_p0 : bus.rf_out2;
          rd_p1   <= rd_p0;
          wen_p1  <= wen_p0;
          ctrl_p1 <= ctrl_p0;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_a     = a_p1;
  assign bus.out_b     = b_p1;
  assign bus.out_rd    = rd_p1;
  assign bus.out_wen   = wen_p1;
  assign bus.out_ctrl  = ctrl_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered dual-read register file model.
module tb_operand_fetch;

  localparam int W = 64;
  localparam int A = 4;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if #(.WORD_SIZE(W), .REG_ADDR_SIZE(A), .CTRL_W(C)) bus ();

  operand_fetch #(.WORD_SIZE(W), .REG_ADDR_SIZE(A), .CTRL_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: read data registered one cycle after address, pre-write value on same-edge write
  logic [W-1:0] regs [1 << A];
  always_ff @(posedge clk) begin
    if (!bus.rf_en) begin
      bus.rf_out1 <= '0;
      bus.rf_out2 <= '0;
    end else begin
      bus.rf_out1 <= (bus.rf_r1 == '0) ? '0 : regs[bus.rf_r1];
      bus.rf_out2 <= (bus.rf_r2 == '0) ? '0 : regs[bus.rf_r2];
      if (bus.rf_write != '0) regs[bus.rf_write] <= bus.rf_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb(input logic [A-1:0] rd, input logic [W-1:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
    step();
    bus.wb_valid = 1'b0;
  endtask

  task automatic present(input logic [A-1:0] rs1, input logic [A-1:0] rs2,
                         input logic [A-1:0] rd, input logic wen, input logic [C-1:0] ctrl);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_wen   = wen;
    bus.in_ctrl  = ctrl;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_wen    = 1'b0;
    bus.in_ctrl   = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;

    // Reset: outputs cleared, writeback suppressed, rf disabled
    step();
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd3;
    bus.wb_data  = 64'hDEAD;
    settle();
    check("rst_rf_write", 64'(bus.rf_write), 64'd0);
    check("rst_rf_en", 64'(bus.rf_en), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_a", bus.out_a, 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.wb_valid = 1'b0;
    rst_n = 1'b1;

    // Preload the register file through the writeback pass-through
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd3;
    bus.wb_data  = 64'h11;
    settle();
    check("wb_rf_write", 64'(bus.rf_write), 64'd3);
    check("wb_rf_data", bus.rf_data, 64'h11);
    check("wb_rf_en", 64'(bus.rf_en), 64'd1);
    step();
    bus.wb_valid = 1'b0;
    wb(4'd5, 64'h22);
    wb(4'd4, 64'h44);
    wb(4'd6, 64'h66);

    // Basic read: rs1=3, rs2=5
    present(4'd3, 4'd5, 4'd1, 1'b0, 8'hA5);
    settle();
    check("t1_in_ready", 64'(bus.in_ready), 64'd1);
    check("t1_rf_r1", 64'(bus.rf_r1), 64'd3);
    check("t1_rf_r2", 64'(bus.rf_r2), 64'd5);
    step();
    bus.in_valid = 1'b0;
    bus.in_rs1   = 4'd9;
    settle();
    check("t1_read_vld", 64'(bus.out_valid), 64'd0);
    check("t1_read_rdy", 64'(bus.in_ready), 64'd0);
    check("t1_read_r1_held", 64'(bus.rf_r1), 64'd3);
    step();
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_a", bus.out_a, 64'h11);
    check("t1_out_b", bus.out_b, 64'h22);
    check("t1_out_ctrl", 64'(bus.out_ctrl), 64'hA5);
    check("t1_out_rd", 64'(bus.out_rd), 64'd1);
    check("t1_out_wen", 64'(bus.out_wen), 64'd0);
    step();
    check("t1_idle_vld", 64'(bus.out_valid), 64'd0);

    // RAW stall on rd=4 resolved by a same-cycle forwarded writeback
    present(4'd0, 4'd0, 4'd4, 1'b1, 8'h01);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    present(4'd4, 4'd3, 4'd2, 1'b0, 8'h02);
    settle();
    check("t2_raw_stall0", 64'(bus.in_ready), 64'd0);
    step();
    check("t2_raw_stall1", 64'(bus.in_ready), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd4;
    bus.wb_data  = 64'h99;
    settle();
    check("t2_raw_clear", 64'(bus.in_ready), 64'd1);
    step();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("t2_fwd_a", bus.out_a, 64'h99);
    check("t2_out_b", bus.out_b, 64'h11);
    check("t2_ctrl", 64'(bus.out_ctrl), 64'h02);
    step();

    // Register 0: never pending, reads as zero
    present(4'd0, 4'd5, 4'd0, 1'b1, 8'h03);
    settle();
    check("t3_rdy", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    check("t3_out_a", bus.out_a, 64'd0);
    check("t3_out_b", bus.out_b, 64'h22);
    check("t3_out_wen", 64'(bus.out_wen), 64'd1);
    check("t3_out_rd", 64'(bus.out_rd), 64'd0);
    step();
    present(4'd0, 4'd0, 4'd0, 1'b1, 8'h04);
    settle();
    check("t3_rd0_no_pend", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    // Backpressure in HOLD for five cycles
    bus.out_ready = 1'b0;
    present(4'd5, 4'd3, 4'd1, 1'b0, 8'h05);
    step();
    bus.in_valid = 1'b0;
    step();
    present(4'd3, 4'd3, 4'd1, 1'b0, 8'h06);
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_hold_vld", 64'(bus.out_valid), 64'd1);
      check("t4_hold_a", bus.out_a, 64'h22);
      check("t4_hold_b", bus.out_b, 64'h11);
      check("t4_hold_rdy", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("t4_release_vld", 64'(bus.out_valid), 64'd0);
    check("t4_release_rdy", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    settle();
    check("t4_accept_after_hold", 64'(bus.in_ready), 64'd0);
    step();
    check("t4_new_out_a", bus.out_a, 64'h11);
    check("t4_new_ctrl", 64'(bus.out_ctrl), 64'h06);
    step();

    // Same-cycle set and clear of bit 7: set wins
    present(4'd0, 4'd0, 4'd7, 1'b1, 8'h07);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd7;
    bus.wb_data  = 64'h77;
    settle();
    check("t5_rdy", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    step();
    step();
    present(4'd3, 4'd7, 4'd2, 1'b0, 8'h08);
    settle();
    check("t5_set_wins_stall", 64'(bus.in_ready), 64'd0);
    step();
    check("t5_stall_hold", 64'(bus.in_ready), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 4'd7;
    bus.wb_data  = 64'h78;
    settle();
    check("t5_clear_rdy", 64'(bus.in_ready), 64'd1);
    step();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("t5_fwd_b", bus.out_b, 64'h78);
    check("t5_out_a", bus.out_a, 64'h11);
    step();

    // Reset while in READ drops the in-flight instruction and pending bits
    present(4'd0, 4'd0, 4'd6, 1'b1, 8'h09);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    present(4'd3, 4'd5, 4'd2, 1'b0, 8'h0A);
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    check("t6_rf_en_low", 64'(bus.rf_en), 64'd0);
    step();
    check("t6_rst_vld", 64'(bus.out_valid), 64'd0);
    check("t6_rst_out_a", bus.out_a, 64'd0);
    step();
    check("t6_rst_vld_after", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    present(4'd6, 4'd6, 4'd2, 1'b0, 8'h0B);
    settle();
    check("t6_post_rst_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    check("t6_out_a", bus.out_a, 64'h66);
    check("t6_out_b", bus.out_b, 64'h66);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the dual-read register file.
- Accepts decoded instructions over a valid/ready handshake and tracks pending destination writes in a scoreboard, stalling on RAW/WAW hazards.
- Drives the register-file read/write ports, absorbs its 1-cycle registered read latency, and forwards a same-cycle writeback.
- Presents captured operands to execute over a second valid/ready handshake.

Parameters:
WORD_SIZE  64  operand/data width; matches register file
REG_ADDR_SIZE  4  register index width; NUM_REGS = 1 << REG_ADDR_SIZE
CTRL_W  8  opaque control payload carried alongside the instruction

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  instruction accepted when in_valid & in_ready
in_rs1  in  REG_ADDR_SIZE  source 1 index
in_rs2  in  REG_ADDR_SIZE  source 2 index
in_rd  in  REG_ADDR_SIZE  destination index
in_wen  in  1  instruction writes in_rd
in_ctrl  in  CTRL_W  payload
rf_en  out  1  register file enable
rf_r1  out  REG_ADDR_SIZE  register file read address 1
rf_r2  out  REG_ADDR_SIZE  register file read address 2
rf_write  out  REG_ADDR_SIZE  register file write address; 0 means no write
rf_data  out  WORD_SIZE  register file write data
rf_out1  in  WORD_SIZE  register file read data 1, valid one cycle after address
rf_out2  in  WORD_SIZE  register file read data 2
wb_valid  in  1  writeback strobe from downstream
wb_rd  in  REG_ADDR_SIZE  writeback index
wb_data  in  WORD_SIZE  writeback value
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_a  out  WORD_SIZE  operand 1
out_b  out  WORD_SIZE  operand 2
out_rd  out  REG_ADDR_SIZE  destination
out_wen  out  1  destination write flag
out_ctrl  out  CTRL_W  payload

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE; scoreboard all 0; forward flags 0.
  - out_valid=0; out_a, out_b, out_rd, out_wen, out_ctrl = 0.
  - wb ignored.
- rf_en = rst_n (combinational). The register file therefore zeroes its outputs during reset and writes whenever out of reset.
- rf_write = (wb_valid & rst_n) ? wb_rd : 0; rf_data = wb_data. Writeback is combinational pass-through with no latency.
- Hazard (combinational, in IDLE), any of:
  - rs1 pending and not cleared this cycle
  - rs2 pending and not cleared this cycle
  - in_wen & rd!=0 & rd pending
- A pending bit counts as cleared this cycle when wb_valid & wb_rd equals that index. Index 0 is never pending.
- in_ready = (state==IDLE) & ~hazard.
- rf_r1 = in_rs1 and rf_r2 = in_rs2 while IDLE; otherwise held at the last accepted indices.
- IDLE -> READ on accept at edge N:
  - Latch rd, wen, ctrl.
  - fwd1 = wb_valid & wb_rd==in_rs1 & in_rs1!=0; fwd2 likewise for rs2.
  - Latch wb_data into fwd_data. The register file returns the pre-write value for a same-edge write, so forwarding is mandatory.
- READ (cycle N+1) -> HOLD at edge N+1:
  - out_a = fwd1 ? fwd_data : rf_out1; out_b likewise with fwd2 and rf_out2.
  - out_valid <= 1.
- HOLD: outputs stable while out_valid & ~out_ready. On out_ready, go to IDLE and set out_valid <= 0.
- Latency: accept at edge N -> out_valid high from edge N+1. Throughput is at most one instruction per 3 cycles.
- Scoreboard:
  - Set bit rd on accept with in_wen & rd!=0.
  - Clear bit wb_rd on wb_valid.
  - Same index set and cleared in the same cycle: set wins.
  - Bit 0 is constant 0.
- Writeback to a non-pending index: performed, scoreboard unchanged.
- Reset in READ or HOLD: in-flight instruction discarded, all pending bits dropped.

Decomposition:
- Package operand_fetch_pkg: state enum {IDLE, READ, HOLD}; NUM_REGS constant; helper function for index-is-zero.
- One sub-module, opfetch_scoreboard (NUM_REGS-bit set/clear vector with three combinational lookup ports).

Test Plan:
- Reset, then accept rs1=3, rs2=5 with regs 3=0x11, 5=0x22 -> out_valid at N+1, out_a=0x11, out_b=0x22.
- Accept rd=4 wen=1, then next instruction with rs1=4 -> in_ready=0 until wb_valid rd=4 data=0x99. On that same cycle it is accepted, and out_a=0x99 via forward (not the stale value).
- rs1=0 or rd=0 wen=1 -> no stall, out_a=0, scoreboard unchanged; following rs1=0 is not stalled.
- Hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; release -> IDLE next cycle, new accept allowed.
- Same cycle: accept rd=7 wen=1 and wb_valid rd=7 -> bit 7 remains set; a later rs2=7 stalls until a second writeback.
- Assert rst_n=0 during READ -> next cycle out_valid=0, scoreboard clear, rf_en=0; after release, a previously stalled rs accepts immediately.
